// File: rtl/cba_pkg.sv
// rtl/cba_pkg.sv - shared constants and helpers for the pipelined carry-bypass adder
package cba_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cba_slice.sv
// rtl/cba_slice.sv - combinational BLOCK-bit ripple slice with carry-bypass mux
module cba_slice #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             ci_i,
    output logic [BLOCK-1:0] s_o,
    output logic             co_o
);

    logic [BLOCK:0] c;
    logic           prop;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = ci_i;
        for (int i = 0; i < BLOCK; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | ((a_i[i] ^ b_i[i]) & c[i]);
        end
    end

    // A fully propagating slice forwards its carry-in without waiting on the ripple.
    assign prop = &(a_i ^ b_i);
    assign co_o = prop ? ci_i : c[BLOCK];

endmodule

// File: rtl/cba_pipe_adder.sv
// rtl/cba_pipe_adder.sv - pipelined carry-bypass add/sub, one register stage per slice
module cba_pipe_adder
    import cba_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = nblk(WIDTH, BLOCK);

    if ((WIDTH % BLOCK) != 0 || NBLK < 1) begin : g_param_check
        $error("cba_pipe_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic [WIDTH-1:0] a_q [NBLK];
    logic [WIDTH-1:0] b_q [NBLK];
    logic [WIDTH-1:0] s_q [NBLK];
    logic [NBLK-1:0]  c_q;
    logic [NBLK-1:0]  vld_q;
    logic             ovf_q;

    logic [WIDTH-1:0] a_d  [NBLK];
    logic [WIDTH-1:0] b_d  [NBLK];
    logic [WIDTH-1:0] s_in [NBLK];
    logic [WIDTH-1:0] s_d  [NBLK];
    logic [NBLK-1:0]  c_in;
    logic [NBLK-1:0]  c_d;
    logic [NBLK-1:0]  vld_d;
    logic             ovf_d;
    logic [NBLK:0]    rdy;

    function automatic logic [WIDTH-1:0] put_slice(input logic [WIDTH-1:0] v,
                                                    input logic [BLOCK-1:0] s,
                                                    input int k);
        logic [WIDTH-1:0] r;
        r = v;
        r[k*BLOCK +: BLOCK] = s;
        return r;
    endfunction

    // A stage may load when it is empty or its successor is moving this cycle.
    always_comb begin
        rdy       = '0;
        rdy[NBLK] = out_ready;
        for (int k = NBLK - 1; k >= 0; k--) begin
            rdy[k] = !vld_q[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < NBLK; k++) begin : g_stage
        logic [BLOCK-1:0] s_slice;

        if (k == 0) begin : g_head
            assign a_d[0]   = a;
            assign b_d[0]   = (op == OP_SUB) ? ~b : b;
            assign c_in[0]  = (op == OP_SUB) ? 1'b1 : cin;
            assign s_in[0]  = '0;
            assign vld_d[0] = in_valid;
        end else begin : g_body
            assign a_d[k]   = a_q[k-1];
            assign b_d[k]   = b_q[k-1];
            assign c_in[k]  = c_q[k-1];
            assign s_in[k]  = s_q[k-1];
            assign vld_d[k] = vld_q[k-1];
        end

        cba_slice #(.BLOCK(BLOCK)) u_slice (
            .a_i  (a_d[k][k*BLOCK +: BLOCK]),
            .b_i  (b_d[k][k*BLOCK +: BLOCK]),
            .ci_i (c_in[k]),
            .s_o  (s_slice),
            .co_o (c_d[k])
        );

        assign s_d[k] = put_slice(s_in[k], s_slice, k);
    end

    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    assign ovf_d = s_d[NBLK-1][WIDTH-1] ^ a_d[NBLK-1][WIDTH-1]
                 ^ b_d[NBLK-1][WIDTH-1] ^ c_d[NBLK-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < NBLK; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NBLK; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= vld_d[k];
                    if (vld_d[k]) begin
                        s_q[k] <= s_d[k];
                        c_q[k] <= c_d[k];
                        if (k < NBLK - 1) begin
                            a_q[k] <= a_d[k];
                            b_q[k] <= b_d[k];
                        end
                    end
                end
            end
            if (rdy[NBLK-1] && vld_d[NBLK-1]) begin
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = vld_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cba_pipe_adder.sv
// tb/tb_cba_pipe_adder.sv - randomized self-checking bench for cba_pipe_adder
module tb_cba_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv, ir, op, cin, ov, ordy, cout, ovf;
    logic [31:0] a, b, sum;
    logic        iv16, ir16, op16, cin16, ov16, ordy16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    int checks = 0;
    int errors = 0;

    cba_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .op(op),
        .a(a), .b(b), .cin(cin), .out_valid(ov), .out_ready(ordy),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    cba_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .op(op16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(ordy16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    // Reference: unsigned/signed integer arithmetic; returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(input int w, input logic o,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic ci);
        longint ux, uy, mask, half, full, sx, sy, sr, t, lci;
        logic [63:0] sv;
        logic cy, vf;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        mask = full - 1;
        ux   = {32'b0, x} & mask;
        uy   = {32'b0, y} & mask;
        lci  = ci ? 1 : 0;
        sx   = (ux >= half) ? ux - full : ux;
        sy   = (uy >= half) ? uy - full : uy;
        if (o == 1'b0) begin
            t  = ux + uy + lci;
            cy = (t >= full);
            sr = sx + sy + lci;
        end else begin
            t  = ux - uy;
            cy = (ux >= uy);
            sr = sx - sy;
        end
        sv = t & mask;
        vf = (sr < -half) || (sr > half - 1);
        return {vf, cy, sv[31:0]};
    endfunction

    task automatic run_one(input logic o, input logic [31:0] x, input logic [31:0] y,
                           input logic ci, output int lat, output logic [33:0] res);
        @(negedge clk);
        iv = 1'b1; op = o; a = x; b = y; cin = ci; ordy = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        lat = -1;
        res = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ov) begin
                lat = i;
                res = {ovf, cout, sum};
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ov !== 1'b0 || sum !== 32'h0) begin
            errors++; $display("FAIL reset_out valid=%b sum=%h required valid=0 sum=0", ov, sum);
        end
        checks++;
        if (cout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags cout=%b ovf=%b required 0 0", cout, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            errors++; $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", ir, ov);
        end
    endtask

    // Fields: op, cin, a, b, expected sum, expected cout, expected ovf.
    localparam logic [99:0] VEC [6] = '{
        {1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
        {1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
        {1'b0, 1'b1, 32'h00FFFFFF, 32'hFF000000, 32'h00000000, 1'b1, 1'b0},
        {1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0},
        {1'b1, 1'b0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1},
        {1'b1, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000007, 1'b1, 1'b0}
    };

    task automatic test_add_sub_edges;
        logic [99:0] e;
        logic [33:0] res;
        int lat;
        for (int i = 0; i < 6; i++) begin
            e = VEC[i];
            run_one(e[99], e[97:66], e[65:34], e[98], lat, res);
            checks++;
            if (lat != 4) begin
                errors++; $display("FAIL edge%0d_latency got %0d required 4", i, lat);
            end
            checks++;
            if (res[31:0] !== e[33:2]) begin
                errors++; $display("FAIL edge%0d_sum got %h required %h", i, res[31:0], e[33:2]);
            end
            checks++;
            if (res[33:32] !== {e[0], e[1]}) begin
                errors++; $display("FAIL edge%0d_flags ovf,cout got %b required %b", i, res[33:32], {e[0], e[1]});
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] xa [6];
        logic [31:0] xb [6];
        logic        xo [6];
        logic        xc [6];
        logic [33:0] exp_q [$];
        logic [33:0] held, e;
        int sent, recv, last_rx;
        for (int i = 0; i < 6; i++) begin
            xa[i] = $urandom; xb[i] = $urandom;
            xo[i] = 1'($urandom_range(0, 1)); xc[i] = 1'($urandom_range(0, 1));
        end
        sent = 0; recv = 0; last_rx = -1; held = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            ordy = (cyc >= 8);
            if (sent < 6) begin
                iv = 1'b1; op = xo[sent]; a = xa[sent]; b = xb[sent]; cin = xc[sent];
            end else begin
                iv = 1'b0;
            end
            #1;
            if (cyc == 4) begin
                checks++;
                if (ir !== 1'b0 || ov !== 1'b1) begin
                    errors++; $display("FAIL bp_full in_ready=%b out_valid=%b required 0 1", ir, ov);
                end
                held = {ovf, cout, sum};
            end
            if (cyc == 7) begin
                checks++;
                if ({ovf, cout, sum} !== held || ov !== 1'b1) begin
                    errors++; $display("FAIL bp_hold got %h required %h", {ovf, cout, sum}, held);
                end
            end
            if (ov && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra result %h required none", sum);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, cout, sum} !== e) begin
                        errors++; $display("FAIL bp_result%0d got %h required %h", recv, {ovf, cout, sum}, e);
                    end
                end
                recv++;
                last_rx = cyc;
            end
            if (iv && ir) begin
                exp_q.push_back(model(32, op, a, b, cin));
                sent++;
            end
        end
        iv = 1'b0;
        checks++;
        if (sent != 6 || recv != 6 || last_rx != 13) begin
            errors++; $display("FAIL bp_count sent=%0d recv=%0d last=%0d required 6 6 13", sent, recv, last_rx);
        end
    endtask

    task automatic test_reset_midstream;
        logic [33:0] res;
        logic [31:0] x, y;
        int lat;
        bit seen, stale;
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            iv = 1'b1; op = 1'b0; cin = 1'b0; a = 32'h12345678 + i; b = 32'h1;
        end
        @(negedge clk);
        iv = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = ov;
        end
        checks++;
        if (!seen || sum !== 32'h12345679) begin
            errors++; $display("FAIL mid_pre out_valid=%b sum=%h required 1 12345679", seen, sum);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ov !== 1'b0 || sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL mid_reset valid=%b sum=%h cout=%b ovf=%b required all 0", ov, sum, cout, ovf);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ordy = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov) stale = 1;
        end
        checks++;
        if (stale) begin
            errors++; $display("FAIL mid_stale out_valid seen=1 required 0");
        end
        x = $urandom; y = $urandom;
        run_one(1'b0, x, y, 1'b1, lat, res);
        checks++;
        if (lat != 4 || res !== model(32, 1'b0, x, y, 1'b1)) begin
            errors++; $display("FAIL mid_next lat=%0d res=%h required 4 %h", lat, res, model(32, 1'b0, x, y, 1'b1));
        end
    endtask

    task automatic test_random16;
        logic [33:0] q [$];
        logic [33:0] e;
        logic [17:0] prev_val;
        logic pend, prev_ov, prev_or;
        int issued, recv;
        issued = 0; recv = 0; pend = 0; prev_ov = 0; prev_or = 1; prev_val = '0;
        for (int cyc = 0; cyc < 60000 && (issued < 10000 || q.size() > 0); cyc++) begin
            @(negedge clk);
            if (!pend) begin
                if (issued < 10000 && $urandom_range(0, 3) != 0) begin
                    iv16 = 1'b1; op16 = 1'($urandom_range(0, 1)); cin16 = 1'($urandom_range(0, 1));
                    a16 = 16'($urandom); b16 = 16'($urandom);
                end else begin
                    iv16 = 1'b0;
                end
            end
            ordy16 = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_ov && !prev_or) begin
                checks++;
                if (ov16 !== 1'b1 || {ovf16, cout16, sum16} !== prev_val) begin
                    errors++; $display("FAIL r16_hold cyc=%0d got %h required %h", cyc, {ovf16, cout16, sum16}, prev_val);
                end
            end
            if (ov16 && ordy16) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL r16_extra result %h required none", sum16);
                end else begin
                    e = q.pop_front();
                    if ({ovf16, cout16, sum16} !== {e[33:32], e[15:0]}) begin
                        errors++; $display("FAIL r16_result%0d got %h required %h", recv, {ovf16, cout16, sum16}, {e[33:32], e[15:0]});
                    end
                end
                recv++;
            end
            if (iv16 && ir16) begin
                q.push_back(model(16, op16, {16'b0, a16}, {16'b0, b16}, cin16));
                issued++;
                pend = 0;
            end else begin
                pend = iv16;
            end
            prev_ov = ov16; prev_or = ordy16; prev_val = {ovf16, cout16, sum16};
        end
        iv16 = 1'b0;
        checks++;
        if (issued != 10000 || recv != 10000 || q.size() != 0) begin
            errors++; $display("FAIL r16_count issued=%0d recv=%0d left=%0d required 10000 10000 0", issued, recv, q.size());
        end
    endtask

    initial begin
        iv = 0; op = 0; a = '0; b = '0; cin = 0; ordy = 1;
        iv16 = 0; op16 = 0; a16 = '0; b16 = '0; cin16 = 0; ordy16 = 1;
        rst_n = 0;
        test_reset();
        test_add_sub_edges();
        test_backpressure();
        test_reset_midstream();
        test_random16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
